// File: rtl/pipo_load_arbiter_pkg.sv
// ============================================================================
// Module      : pipo_arb_pkg
// Description : Shared FSM encoding and sizing constants for pipo_load_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipo_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_t;

    localparam int unsigned C_DATA_WIDTH_DEF  = 8;
    localparam int unsigned C_HOLD_CYCLES_MAX = 15;
    localparam int unsigned C_HOLD_CNT_W      = 4;

    // Round-robin pick: a lone request wins; on contention the non-owner wins.
    function automatic logic rr_pick(input logic [1:0] req_i, input logic owner_i);
        if (req_i == 2'b11) begin
            return ~owner_i;
        end
        return req_i[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipo_load_arbiter_if.sv
// ============================================================================
// Module      : pipo_load_arbiter_if
// Description : Request/data/status bundle of the arbiter; load counters are
//               present only when PIPO_ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipo_load_arbiter_if
    import pipo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH_DEF
);

    logic [1:0]            req;
    logic [DATA_WIDTH-1:0] data0;
    logic [DATA_WIDTH-1:0] data1;
    logic [1:0]            ack;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_valid;
    logic                  busy;
    logic                  owner;
`ifdef PIPO_ARB_STATS_EN
    logic [15:0]           load_count0;
    logic [15:0]           load_count1;

    modport master (output req, data0, data1,
                    input  ack, q, q_valid, busy, owner, load_count0, load_count1);
    modport slave  (input  req, data0, data1,
                    output ack, q, q_valid, busy, owner, load_count0, load_count1);
`else
    modport master (output req, data0, data1,
                    input  ack, q, q_valid, busy, owner);
    modport slave  (input  req, data0, data1,
                    output ack, q, q_valid, busy, owner);
`endif

endinterface

`default_nettype wire

// File: rtl/pipo_load_arbiter_reg.sv
// ============================================================================
// Module      : pipo_reg_en
// Description : Parallel-in parallel-out register with load enable and
//               synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipo_reg_en #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipo_load_arbiter.sv
// ============================================================================
// Module      : pipo_load_arbiter
// Description : Two-requester round-robin arbiter loading a shared register,
//               with a post-load hold window. Optional per-requester load
//               counters under PIPO_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipo_load_arbiter
    import pipo_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = C_DATA_WIDTH_DEF,
    parameter int HOLD_CYCLES = 2
) (
    input wire logic           clk,
    input wire logic           reset,
    pipo_load_arbiter_if.slave bus
);

    // Counter is preloaded with HOLD_CYCLES-1 so HOLD spans exactly HOLD_CYCLES cycles.
    localparam logic [C_HOLD_CNT_W-1:0] C_HOLD_LOAD = C_HOLD_CNT_W'(HOLD_CYCLES - 1);

    arb_state_t              r_state;
    arb_state_t              w_next_state;
    logic                    r_grant;
    logic                    w_grant_next;
    logic [C_HOLD_CNT_W-1:0] r_hold_cnt;
    logic [C_HOLD_CNT_W-1:0] w_hold_cnt_next;
    logic                    r_owner;
    logic                    r_q_valid;
    logic                    w_load;
    logic [1:0]              w_ack;
    logic [DATA_WIDTH-1:0]   w_d;
    logic [DATA_WIDTH-1:0]   w_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_grant    <= 1'b0;
            r_hold_cnt <= '0;
            r_owner    <= 1'b1;
            r_q_valid  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_grant    <= w_grant_next;
            r_hold_cnt <= w_hold_cnt_next;
            if (w_load) begin
                r_owner   <= r_grant;
                r_q_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_grant_next    = r_grant;
        w_hold_cnt_next = r_hold_cnt;
        w_load          = 1'b0;
        w_ack           = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (bus.req != 2'b00) begin
                    w_next_state = ST_LOAD;
                    w_grant_next = rr_pick(bus.req, r_owner);
                end
            end
            ST_LOAD: begin
                // A withdrawn request or a concurrent reset aborts the load.
                if (bus.req[r_grant] && !reset) begin
                    w_load          = 1'b1;
                    w_ack[r_grant]  = 1'b1;
                    w_next_state    = ST_HOLD;
                    w_hold_cnt_next = C_HOLD_LOAD;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (r_hold_cnt == '0) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_hold_cnt_next = r_hold_cnt - 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_d = r_grant ? bus.data1 : bus.data0;

    pipo_reg_en #(
        .WIDTH (DATA_WIDTH)
    ) u_reg (
        .clk   (clk),
        .reset (reset),
        .load  (w_load),
        .d     (w_d),
        .q     (w_q)
    );

    assign bus.ack     = w_ack;
    assign bus.q       = w_q;
    assign bus.q_valid = r_q_valid;
    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.owner   = r_owner;

`ifdef PIPO_ARB_STATS_EN
    logic [15:0] r_load_count0;
    logic [15:0] r_load_count1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_load_count0 <= '0;
            r_load_count1 <= '0;
        end else if (w_load) begin
            if (!r_grant && r_load_count0 != 16'hFFFF) begin
                r_load_count0 <= r_load_count0 + 16'd1;
            end
            if (r_grant && r_load_count1 != 16'hFFFF) begin
                r_load_count1 <= r_load_count1 + 16'd1;
            end
        end
    end

    assign bus.load_count0 = r_load_count0;
    assign bus.load_count1 = r_load_count1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipo_load_arbiter.sv
// ============================================================================
// Module      : tb_pipo_load_arbiter
// Description : Directed self-checking bench for pipo_load_arbiter
//               (stats checks active when PIPO_ARB_STATS_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipo_load_arbiter;

    localparam int DATA_WIDTH  = 8;
    localparam int HOLD_CYCLES = 2;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    pipo_load_arbiter_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

    pipo_load_arbiter #(
        .DATA_WIDTH  (DATA_WIDTH),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.busy && k < 20) begin
            tick();
            k++;
        end
        chk("idle_timeout", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_q   [3];
        logic [1:0] exp_ack [3];
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        bus.req   = 2'b11;
        bus.data0 = 8'h00;
        bus.data1 = 8'h00;

        // Reset state, with requests present while reset is high
        tick();
        tick();
        chk("rst_ack",     {30'd0, bus.ack},  32'd0);
        chk("rst_q",       {24'd0, bus.q},    32'd0);
        chk("rst_q_valid", {31'd0, bus.q_valid}, 32'd0);
        chk("rst_busy",    {31'd0, bus.busy}, 32'd0);
        chk("rst_owner",   {31'd0, bus.owner}, 32'd1);
        bus.req = 2'b00;
        reset   = 1'b0;
        tick();

        // Single request: ack in cycle 1, q in cycle 2
        bus.req   = 2'b01;
        bus.data0 = 8'hA5;
        tick();
        chk("a_ack",   {30'd0, bus.ack},  32'h1);
        chk("a_busy",  {31'd0, bus.busy}, 32'd1);
        chk("a_q_pre", {24'd0, bus.q},    32'h0);
        tick();
        chk("a_q",       {24'd0, bus.q},       32'hA5);
        chk("a_q_valid", {31'd0, bus.q_valid}, 32'd1);
        chk("a_owner",   {31'd0, bus.owner},   32'd0);
        chk("a_ack_off", {30'd0, bus.ack},     32'd0);
        bus.req = 2'b00;
        wait_idle();

        // Contention after reset: alternating loads 4 cycles apart
        pulse_reset();
        exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h11;
        exp_ack[0] = 2'b01; exp_ack[1] = 2'b10; exp_ack[2] = 2'b01;
        bus.req   = 2'b11;
        bus.data0 = 8'h11;
        bus.data1 = 8'h22;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b_ack", {30'd0, bus.ack}, {30'd0, exp_ack[i]});
            tick();
            chk("b_q", {24'd0, bus.q}, {24'd0, exp_q[i]});
            tick();
            chk("b_hold_ack",  {30'd0, bus.ack},  32'd0);
            chk("b_hold_busy", {31'd0, bus.busy}, 32'd1);
            tick();
            chk("b_idle_busy", {31'd0, bus.busy}, 32'd0);
        end
        bus.req = 2'b00;
        tick();

        // Request withdrawn in the LOAD cycle
        bus.req   = 2'b01;
        bus.data0 = 8'h77;
        tick();
        bus.req = 2'b00;
        #1;
        chk("c_ack", {30'd0, bus.ack}, 32'd0);
        tick();
        chk("c_busy",  {31'd0, bus.busy},  32'd0);
        chk("c_q",     {24'd0, bus.q},     32'h11);
        chk("c_owner", {31'd0, bus.owner}, 32'd0);

        // Reset during HOLD after loading 0x3C
        bus.req   = 2'b10;
        bus.data1 = 8'h3C;
        tick();
        tick();
        chk("d_q", {24'd0, bus.q}, 32'h3C);
        bus.req = 2'b00;
        reset   = 1'b1;
        tick();
        chk("d_q_rst",     {24'd0, bus.q},       32'h0);
        chk("d_valid_rst", {31'd0, bus.q_valid}, 32'd0);
        chk("d_busy_rst",  {31'd0, bus.busy},    32'd0);
        chk("d_owner_rst", {31'd0, bus.owner},   32'd1);
        reset = 1'b0;
        tick();

        // Request change during HOLD is ignored until IDLE
        bus.req   = 2'b01;
        bus.data0 = 8'h55;
        tick();
        chk("e_ack0", {30'd0, bus.ack}, 32'h1);
        tick();
        chk("e_q0", {24'd0, bus.q}, 32'h55);
        bus.req   = 2'b10;
        bus.data1 = 8'h66;
        #1;
        chk("e_hold_ack1", {30'd0, bus.ack}, 32'd0);
        tick();
        chk("e_hold_ack2", {30'd0, bus.ack}, 32'd0);
        tick();
        chk("e_idle_ack",  {30'd0, bus.ack},  32'd0);
        chk("e_idle_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        chk("e_ack1", {30'd0, bus.ack}, 32'h2);
        tick();
        chk("e_q1",    {24'd0, bus.q},     32'h66);
        chk("e_owner", {31'd0, bus.owner}, 32'd1);
        bus.req = 2'b00;
        wait_idle();

`ifdef PIPO_ARB_STATS_EN
        // Five loads by requester 1
        pulse_reset();
        chk("s_cnt0_rst", {16'd0, bus.load_count0}, 32'd0);
        chk("s_cnt1_rst", {16'd0, bus.load_count1}, 32'd0);
        bus.req   = 2'b10;
        bus.data1 = 8'h9E;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s_ack", {30'd0, bus.ack}, 32'h2);
            tick();
            tick();
            tick();
        end
        bus.req = 2'b00;
        wait_idle();
        chk("s_cnt0", {16'd0, bus.load_count0}, 32'd0);
        chk("s_cnt1", {16'd0, bus.load_count1}, 32'd5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipo_load_arbiter.md
PIPO_LOAD_ARBITER -- requirements
Module: pipo_load_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of the shared register and of each data input.
REQ-002 Parameter HOLD_CYCLES, default 2, legal range 1..15, SHALL set the minimum number of cycles q is held after a load before the next grant.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 req  input  2  SHALL carry the per-requester load request; bit i belongs to requester i.
REQ-006 data0  input  DATA_WIDTH  SHALL carry requester 0 load data.
REQ-007 data1  input  DATA_WIDTH  SHALL carry requester 1 load data.
REQ-008 ack  output  2  SHALL be the one-hot load acknowledge per requester.
REQ-009 q  output  DATA_WIDTH  SHALL be the shared register contents.
REQ-010 q_valid  output  1  SHALL be high once the register holds requester-loaded data.
REQ-011 busy  output  1  SHALL be high whenever the FSM is not IDLE.
REQ-012 owner  output  1  SHALL be the index of the last granted requester.

Function
REQ-013 The FSM SHALL have the states IDLE, LOAD and HOLD.
REQ-014 In IDLE with req != 0, the next state SHALL be LOAD, and the grant SHALL be registered.
REQ-015 The grant SHALL be round-robin: a single request wins outright; when both request, the requester != owner SHALL win.
REQ-016 In LOAD, ack[grant] SHALL be asserted combinationally for exactly that one cycle, and the other ack bit SHALL be 0.
REQ-017 In LOAD with req[grant]=1, q SHALL take data[grant] at the closing edge, q_valid SHALL become 1, owner SHALL become grant, and the next state SHALL be HOLD.
REQ-018 In LOAD with req[grant]=0 (request withdrawn), the load SHALL be aborted: ack=0, q, q_valid and owner unchanged, next state IDLE.
REQ-019 HOLD SHALL last exactly HOLD_CYCLES cycles using a down-counter, and then return to IDLE; req SHALL be ignored during HOLD.
REQ-020 Latency SHALL be: req sampled in IDLE at cycle 0, ack in cycle 1, new q visible in cycle 2.
REQ-021 A req still high on return to IDLE SHALL be treated as a new request.
REQ-022 The minimum spacing between two loads SHALL be 2+HOLD_CYCLES cycles.
REQ-023 q SHALL hold its value in every cycle except the LOAD closing edge.

Reset
REQ-024 When reset=1 at a rising edge, the block SHALL set state=IDLE, q=0, q_valid=0, owner=1, the hold counter to 0 and all statistics counters to 0.
REQ-025 ack SHALL be 0 during any cycle in which reset is high.
REQ-026 Reset asserted during LOAD or HOLD SHALL abandon the operation, and any load in that cycle SHALL be discarded.

Configuration
REQ-027 The macro PIPO_ARB_STATS_EN, when defined, SHALL add the outputs load_count0 and load_count1 (16 bits each), counting completed loads per requester and saturating at 16'hFFFF.
REQ-028 Without PIPO_ARB_STATS_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 The shared package pipo_arb_pkg SHALL hold the FSM state encoding (IDLE=2'd0, LOAD=2'd1, HOLD=2'd2), the default DATA_WIDTH and the HOLD_CYCLES limit.
REQ-030 The register SHALL be a sub-module pipo_reg_en with inputs clk, reset, load and d, output q, and a synchronous clear to 0; the arbiter SHALL drive its load and d inputs.

Verification
REQ-031 The bench SHALL cover: reset, then req=2'b01, data0=8'hA5 -> ack=2'b01 in cycle 1, q=8'hA5 and q_valid=1 in cycle 2, owner=0.
REQ-032 The bench SHALL cover: req=2'b11 held, data0=8'h11, data1=8'h22, HOLD_CYCLES=2 -> loads alternate 8'h11, 8'h22, 8'h11, spaced 4 cycles apart.
REQ-033 The bench SHALL cover: req0 dropped in the LOAD cycle -> ack=0, q unchanged, busy=0 the next cycle.
REQ-034 The bench SHALL cover: reset pulsed in HOLD after loading 8'h3C -> q=0, q_valid=0, busy=0 the next cycle.
REQ-035 The bench SHALL cover, with PIPO_ARB_STATS_EN: 5 loads by requester 1 -> load_count1=5 and load_count0=0.
REQ-036 The bench SHALL cover: req change during HOLD -> no ack until IDLE is re-entered.
